// File: rtl/mesm6_busctl.sv
// rtl/mesm6_busctl.sv - registered CPU data-port bus controller for RAM and memory-mapped devices
module mesm6_busctl #(
  parameter int DATA_W  = 48,
  parameter int NDEV    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [14:0]            cpu_addr,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_done,
  output logic                   cpu_error,
  output logic [14:0]            mem_addr,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_done,
  output logic [14:0]            dev_addr,
  output logic [DATA_W-1:0]      dev_wdata,
  output logic [NDEV-1:0]        dev_read,
  output logic [NDEV-1:0]        dev_write,
  input  logic [NDEV*DATA_W-1:0] dev_rdata,
  input  logic [NDEV-1:0]        dev_done,
  input  logic [NDEV-1:0]        dev_int,
  output logic [47:0]            pic_irq
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t              state;
  logic [15:0]         cnt;
  logic [14:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                op_read;
  logic                sel_ram;
  logic [NDEV-1:0]     sel_dev;

  logic                dec_ram;
  logic [NDEV-1:0]     dec_dev;
  logic                tgt_done;
  logic [DATA_W-1:0]   tgt_rdata;

  // Latched address and write data are shared by RAM and all devices
  assign mem_addr  = addr_q;
  assign dev_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dev_wdata = wdata_q;

  // Decode the address being latched: RAM outside page 0o77, devices count down from 0o77770
  always_comb begin
    dec_ram = (cpu_addr[14:9] != 6'o77);
    dec_dev = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (!dec_ram && cpu_addr[14:3] == 12'(4095 - i))
        dec_dev[i] = 1'b1;
    end
  end

  // Only the selected target's done and read data are ever looked at
  always_comb begin
    tgt_done  = sel_ram ? mem_done : |(dev_done & sel_dev);
    tgt_rdata = mem_rdata;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_dev[i])
        tgt_rdata = dev_rdata[i*DATA_W +: DATA_W];
    end
  end

  // Transaction FSM: latch, strobe once, wait for done or timeout, respond for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_read   <= 1'b0;
      sel_ram   <= 1'b0;
      sel_dev   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      dev_read  <= '0;
      dev_write <= '0;
      cpu_done  <= 1'b0;
      cpu_error <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      dev_read  <= '0;
      dev_write <= '0;
      cpu_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_read || cpu_write) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            op_read <= cpu_read;
            sel_ram <= dec_ram;
            sel_dev <= dec_dev;
            if ((cpu_read ^ cpu_write) && (dec_ram || (|dec_dev))) begin
              state     <= S_REQ;
              mem_read  <= cpu_read & dec_ram;
              mem_write <= cpu_write & dec_ram;
              dev_read  <= cpu_read ? dec_dev : '0;
              dev_write <= cpu_write ? dec_dev : '0;
            end else begin
              // Unmapped or ambiguous request: answer at once with no strobe
              state     <= S_RESP;
              cpu_done  <= 1'b1;
              cpu_error <= 1'b1;
              cpu_rdata <= '0;
            end
          end
        end
        S_REQ: begin
          cnt <= '0;
          if (tgt_done) begin
            state     <= S_RESP;
            cpu_done  <= 1'b1;
            cpu_error <= 1'b0;
            cpu_rdata <= op_read ? tgt_rdata : '0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tgt_done) begin
            state     <= S_RESP;
            cpu_done  <= 1'b1;
            cpu_error <= 1'b0;
            cpu_rdata <= op_read ? tgt_rdata : '0;
          end else if (cnt + 16'd1 == TMO) begin
            state     <= S_RESP;
            cpu_done  <= 1'b1;
            cpu_error <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          cpu_error <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Interrupt lines are registered straight onto the low bits of the PIC request bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pic_irq <= '0;
    end else begin
      pic_irq <= '0;
      pic_irq[NDEV-1:0] <= dev_int;
    end
  end

endmodule

// File: tb/tb_mesm6_busctl.sv
// tb/tb_mesm6_busctl.sv - scoreboard testbench for mesm6_busctl
module tb_mesm6_busctl;

  localparam int DATA_W  = 48;
  localparam int NDEV    = 3;
  localparam int TIMEOUT = 4;
  localparam int T_RAM   = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [14:0]            cpu_addr = '0;
  logic                   cpu_read = 1'b0;
  logic                   cpu_write = 1'b0;
  logic [DATA_W-1:0]      cpu_wdata = '0;
  logic [DATA_W-1:0]      cpu_rdata;
  logic                   cpu_done;
  logic                   cpu_error;
  logic [14:0]            mem_addr;
  logic                   mem_read;
  logic                   mem_write;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata = '0;
  logic                   mem_done = 1'b0;
  logic [14:0]            dev_addr;
  logic [DATA_W-1:0]      dev_wdata;
  logic [NDEV-1:0]        dev_read;
  logic [NDEV-1:0]        dev_write;
  logic [NDEV*DATA_W-1:0] dev_rdata = '0;
  logic [NDEV-1:0]        dev_done = '0;
  logic [NDEV-1:0]        dev_int = '0;
  logic [47:0]            pic_irq;

  mesm6_busctl #(.DATA_W(DATA_W), .NDEV(NDEV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_error(cpu_error),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_read(dev_read),
    .dev_write(dev_write), .dev_rdata(dev_rdata), .dev_done(dev_done),
    .dev_int(dev_int), .pic_irq(pic_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          err;
    logic [47:0] rdata;
    logic [14:0] addr;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [7:0]  vec;
    logic [14:0] addr;
    logic [47:0] wdata;
  } strb_t;

  resp_t resp_q[$];
  strb_t strb_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference decode: 8 = RAM, 0..NDEV-1 = device, -1 = unmapped
  function automatic int decode(input logic [14:0] a);
    int page, k;
    page = int'(a) / 512;
    if (page != 63) return T_RAM;
    k = 4095 - int'(a) / 8;
    if (k < NDEV) return k;
    return -1;
  endfunction

  // Response monitor
  initial forever begin
    @(negedge clk);
    if (!reset && cpu_done) begin
      if (resp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cpu_done cycle=%0d", cyc);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("cpu_error", 64'(cpu_error), 64'(e.err));
        chk("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
        chk("latched_addr", 64'(mem_addr), 64'(e.addr));
      end
    end
  end

  // Strobe monitor
  initial forever begin
    @(negedge clk);
    if (!reset && (mem_read || mem_write || (|dev_read) || (|dev_write))) begin
      if (strb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe cycle=%0d vec=%0h", cyc,
                 {mem_read, mem_write, dev_read, dev_write});
      end else begin
        strb_t s;
        s = strb_q.pop_front();
        chk("strobe_cycle", 64'(cyc), 64'(s.cyc));
        chk("strobe_vec", 64'({mem_read, mem_write, dev_read, dev_write}), 64'(s.vec));
        chk("mem_addr", 64'(mem_addr), 64'(s.addr));
        chk("dev_addr", 64'(dev_addr), 64'(s.addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(s.wdata));
        chk("dev_wdata", 64'(dev_wdata), 64'(s.wdata));
      end
    end
  end

  task automatic randomize_rdata();
    mem_rdata = {$urandom, $urandom};
    for (int i = 0; i < NDEV; i++) dev_rdata[i*DATA_W +: DATA_W] = {$urandom, $urandom};
  endtask

  // lat: cycles after the strobe cycle at which the target raises done (0 = in REQ)
  task automatic txn(input logic [14:0] addr, input bit rd, input bit wr,
                     input logic [47:0] wdata, input int lat,
                     input logic [47:0] rdata, input bit noise);
    int t, start;
    bit mapped, got;
    resp_t e;
    strb_t s;
    t = decode(addr);
    mapped = (t >= 0) && (rd != wr);
    start = cyc;
    e.addr = addr;
    if (!mapped) begin
      e.cyc = start + 1; e.err = 1'b1; e.rdata = '0;
    end else if (lat <= TIMEOUT) begin
      e.cyc = start + 2 + lat; e.err = 1'b0; e.rdata = rd ? rdata : 48'h0;
    end else begin
      e.cyc = start + 2 + TIMEOUT; e.err = 1'b1; e.rdata = '0;
    end
    resp_q.push_back(e);
    if (mapped) begin
      s.cyc = start + 1; s.addr = addr; s.wdata = wdata; s.vec = '0;
      if (t == T_RAM) begin
        s.vec[7] = rd; s.vec[6] = wr;
      end else begin
        s.vec[3 + t] = rd; s.vec[t] = wr;
      end
      strb_q.push_back(s);
    end
    cpu_addr = addr; cpu_read = rd; cpu_write = wr; cpu_wdata = wdata;
    got = 1'b0;
    for (int j = 0; j < 40 && !got; j++) begin
      @(posedge clk); #1;
      randomize_rdata();
      mem_done = 1'b0;
      dev_done = '0;
      if (noise) begin
        mem_done = 1'($urandom);
        dev_done = NDEV'($urandom);
        if (t == T_RAM) mem_done = 1'b0;
        else if (t >= 0) dev_done[t] = 1'b0;
      end
      if (mapped && cyc == start + 1 + lat) begin
        if (t == T_RAM) begin
          mem_done = 1'b1; mem_rdata = rdata;
        end else begin
          dev_done[t] = 1'b1; dev_rdata[t*DATA_W +: DATA_W] = rdata;
        end
      end
      if (cpu_done) begin
        got = 1'b1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout addr=%0o no cpu_done", addr);
      cpu_read = 1'b0;
      cpu_write = 1'b0;
      void'(resp_q.pop_back());
    end
    @(posedge clk); #1;
    mem_done = 1'b0;
    dev_done = '0;
  endtask

  initial begin
    logic [14:0] a;
    int op;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_done", 64'(cpu_done), 0);
    chk("rst_cpu_error", 64'(cpu_error), 0);
    chk("rst_cpu_rdata", 64'(cpu_rdata), 0);
    chk("rst_strobes", 64'({mem_read, mem_write, dev_read, dev_write}), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_pic", 64'(pic_irq), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    txn(15'o01234, 1, 0, 48'h0, 3, 48'h123456789ABC, 0);
    txn(15'o77750, 0, 1, 48'hFFFF, 0, 48'h0, 0);
    txn(15'o77000, 1, 0, 48'h5, 0, 48'h0, 0);
    txn(15'o00010, 1, 1, 48'h7, 0, 48'h0, 0);
    txn(15'o77760, 1, 0, 48'h0, 99, 48'hBAD, 0);
    dev_done[1] = 1'b1;
    @(posedge clk); #1;
    dev_done[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    txn(15'o00500, 1, 0, 48'h0, 2, 48'hCAFE0001, 1);

    // Reset asserted in WAIT aborts the transaction
    dev_int = 3'b101;
    begin
      strb_t s;
      s.cyc = cyc + 1; s.vec = 8'h80; s.addr = 15'o02000; s.wdata = 48'h0;
      strb_q.push_back(s);
    end
    cpu_addr = 15'o02000; cpu_read = 1'b1; cpu_write = 1'b0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    cpu_read = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cpu_done", 64'(cpu_done), 0);
    chk("arst_cpu_rdata", 64'(cpu_rdata), 0);
    chk("arst_strobes", 64'({mem_read, mem_write, dev_read, dev_write}), 0);
    chk("arst_addr", 64'(mem_addr), 0);
    chk("arst_pic", 64'(pic_irq), 0);
    @(negedge clk);
    reset = 1'b0;
    dev_int = '0;
    @(posedge clk); #1;
    txn(15'o03333, 0, 1, 48'hA5A5A5A5A5A5, 1, 48'h0, 0);

    // Interrupt registering
    dev_int = 3'b011;
    @(posedge clk); #1;
    chk("pic_irq_011", 64'(pic_irq), 64'h3);
    for (int i = 0; i < 8; i++) begin
      logic [NDEV-1:0] v;
      v = NDEV'($urandom);
      dev_int = v;
      @(posedge clk); #1;
      chk("pic_irq_rand", 64'(pic_irq), 64'(v));
    end
    dev_int = '0;

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: a = 15'($urandom);
        1: a = {6'o77, 9'($urandom)};
        default: a = {12'(4095 - $urandom_range(0, 2)), 3'($urandom)};
      endcase
      op = $urandom_range(0, 6);
      txn(a, op <= 3, (op == 0) || (op >= 4), {$urandom, $urandom},
          $urandom_range(0, 5), {$urandom, $urandom}, 1'($urandom));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("resp_q_empty", 64'(resp_q.size()), 0);
    chk("strb_q_empty", 64'(strb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
